aud_player: RTL and testbench

- I2S-style DAC transmitter, the playback counterpart of the ADC recorder path.
- Accepts 16-bit PCM samples over a valid/ready handshake into a one-entry holding buffer.
- Serializes each sample MSB-first onto the codec DACDAT line, aligned to DACLRCK edges.
- Sits between the playback sample source (SRAM reader / DSP) and the WM8731 DAC pins. It runs in the bit-clock domain.

---
 rtl/aud_player.sv | 179 +++++++++++++++++
 tb/tb_aud_player.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aud_player.sv
// I2S-style DAC transmitter: one-entry sample buffer, MSB-first shift on DACDAT aligned to DACLRCK.
// Optional macro AUD_PLAYER_STEREO_EN adds i_data_r so the right slot carries its own sample.
module aud_player #(
   parameter int DATA_W         = 16,
   parameter bit UNDERFLOW_ZERO = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_lrc,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
`ifdef AUD_PLAYER_STEREO_EN
   input  logic [DATA_W-1:0] i_data_r,
`endif
   output logic              o_ready,
   output logic              o_dacdat,
   output logic              o_underflow,
   output logic              o_busy,
   output logic [2:0]        o_dbg_state
);

   // Handshake: a sample is accepted on any edge where i_valid & o_ready; o_ready = buffer empty.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT_L  = 3'd1,
      S_SHIFT_L = 3'd2,
      S_WAIT_R  = 3'd3,
      S_SHIFT_R = 3'd4
   } state_t;

   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t              state_q, state_d;
   logic                lrc_p_q, lrc_p_d;
   logic                hold_full_q, hold_full_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic [DATA_W-1:0]   last_q, last_d;
   logic [DATA_W-1:0]   right_q, right_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dacdat_q, dacdat_d;
   logic                underflow_q, underflow_d;
   logic                lrc_fall, lrc_rise, start_l, start_r;
   logic [DATA_W-1:0]   frame_l, frame_r;
`ifdef AUD_PLAYER_STEREO_EN
   logic [DATA_W-1:0]   hold_data_r_q, hold_data_r_d;
   logic [DATA_W-1:0]   last_r_q, last_r_d;
`endif

   assign lrc_fall = lrc_p_q & ~i_lrc;
   assign lrc_rise = ~lrc_p_q & i_lrc;

   always_comb begin
      frame_l = hold_full_q ? hold_data_q : (UNDERFLOW_ZERO ? {DATA_W{1'b0}} : last_q);
`ifdef AUD_PLAYER_STEREO_EN
      frame_r = hold_full_q ? hold_data_r_q : (UNDERFLOW_ZERO ? {DATA_W{1'b0}} : last_r_q);
`else
      frame_r = frame_l;
`endif
   end

   always_comb begin
      state_d     = state_q;
      lrc_p_d     = i_lrc;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      last_d      = last_q;
      right_d     = right_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      dacdat_d    = 1'b0;
      underflow_d = 1'b0;
      start_l     = 1'b0;
      start_r     = 1'b0;
`ifdef AUD_PLAYER_STEREO_EN
      hold_data_r_d = hold_data_r_q;
      last_r_d      = last_r_q;
`endif

      case (state_q)
         S_IDLE: if (i_en) state_d = S_WAIT_L;
         S_WAIT_L: begin
            if (!i_en) state_d = S_IDLE;
            else if (lrc_fall) start_l = 1'b1;
         end
         S_WAIT_R: if (lrc_rise) start_r = 1'b1;
         S_SHIFT_L, S_SHIFT_R: begin
            // An LRC edge mid-slot aborts the slot and starts the next one at once.
            if (lrc_fall) begin
               if (!i_en) state_d = S_IDLE;
               else start_l = 1'b1;
            end else if (lrc_rise) begin
               start_r = 1'b1;
            end else if (cnt_q == CNT_W'(DATA_W)) begin
               state_d = (state_q == S_SHIFT_L) ? S_WAIT_R : S_WAIT_L;
            end else begin
               dacdat_d = shift_q[DATA_W-1];
               shift_d  = shift_q << 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start_l) begin
         state_d     = S_SHIFT_L;
         dacdat_d    = frame_l[DATA_W-1];
         shift_d     = frame_l << 1;
         cnt_d       = CNT_W'(1);
         right_d     = frame_r;
         underflow_d = ~hold_full_q;
         if (hold_full_q) begin
            hold_full_d = 1'b0;
            last_d      = hold_data_q;
`ifdef AUD_PLAYER_STEREO_EN
            last_r_d    = hold_data_r_q;
`endif
         end
      end

      if (start_r) begin
         state_d  = S_SHIFT_R;
         dacdat_d = right_q[DATA_W-1];
         shift_d  = right_q << 1;
         cnt_d    = CNT_W'(1);
      end

      // Accept only into an empty buffer, so it never collides with the consume above.
      if (i_valid && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_data_d = i_data;
`ifdef AUD_PLAYER_STEREO_EN
         hold_data_r_d = i_data_r;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         lrc_p_q     <= 1'b0;
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
         last_q      <= '0;
         right_q     <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         dacdat_q    <= 1'b0;
         underflow_q <= 1'b0;
`ifdef AUD_PLAYER_STEREO_EN
         hold_data_r_q <= '0;
         last_r_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lrc_p_q     <= lrc_p_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         last_q      <= last_d;
         right_q     <= right_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         dacdat_q    <= dacdat_d;
         underflow_q <= underflow_d;
`ifdef AUD_PLAYER_STEREO_EN
         hold_data_r_q <= hold_data_r_d;
         last_r_q      <= last_r_d;
`endif
      end
   end

   assign o_ready     = ~hold_full_q;
   assign o_dacdat    = dacdat_q;
   assign o_underflow = underflow_q;
   assign o_busy      = (state_q == S_SHIFT_L) || (state_q == S_SHIFT_R);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_aud_player.sv
// Directed bench for aud_player: two instances (zero fill and repeat-last fill) share one stimulus.
module tb_aud_player;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        lrc = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] data = '0;
   logic [15:0] data_r = '0;
   logic        dac_a, dac_b, rdy_a, rdy_b, uf_a, uf_b, busy_a, busy_b;
   logic [2:0]  st_a, st_b;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aud_player #(.DATA_W(16), .UNDERFLOW_ZERO(1'b1)) u_dut_zero (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_lrc(lrc), .i_valid(valid), .i_data(data),
`ifdef AUD_PLAYER_STEREO_EN
      .i_data_r(data_r),
`endif
      .o_ready(rdy_a), .o_dacdat(dac_a), .o_underflow(uf_a), .o_busy(busy_a), .o_dbg_state(st_a)
   );

   aud_player #(.DATA_W(16), .UNDERFLOW_ZERO(1'b0)) u_dut_last (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_lrc(lrc), .i_valid(valid), .i_data(data),
`ifdef AUD_PLAYER_STEREO_EN
      .i_data_r(data_r),
`endif
      .o_ready(rdy_b), .o_dacdat(dac_b), .o_underflow(uf_b), .o_busy(busy_b), .o_dbg_state(st_b)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one sample and waits (bounded) until an edge accepts it.
   task automatic offer(input logic [15:0] d);
      bit done = 1'b0;
      valid  = 1'b1;
      data   = d;
      data_r = d;
      for (int t = 0; t < 40 && !done; t++) begin
         if (rdy_a) done = 1'b1;
         step();
      end
      valid = 1'b0;
      check("offer_accept", 32'(done), 32'd1);
   endtask

   // Drives one LRC slot of len edges; checks both serial outputs bit by bit.
   task automatic run_slot(input logic l, input logic [15:0] wa, input logic [15:0] wb,
                           input int len, input logic uf, input logic rdy);
      lrc = l;
      for (int k = 0; k < len; k++) begin
         step();
         if (k < 16) begin
            check("dac_zero_fill", 32'(dac_a), 32'(wa[15-k]));
            check("dac_last_fill", 32'(dac_b), 32'(wb[15-k]));
         end else begin
            check("dac_pad_a", 32'(dac_a), 32'd0);
            check("dac_pad_b", 32'(dac_b), 32'd0);
         end
         check("underflow_a", 32'(uf_a), (k == 0) ? 32'(uf) : 32'd0);
         check("underflow_b", 32'(uf_b), (k == 0) ? 32'(uf) : 32'd0);
         if (k == 0) begin
            check("ready_slot_start", 32'(rdy_a), 32'(rdy));
            check("busy_slot_start", 32'(busy_a), 32'd1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step();
      step();
      check("rst_dac", 32'(dac_a), 32'd0);
      check("rst_ready", 32'(rdy_a), 32'd1);
      check("rst_uf", 32'(uf_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_state", 32'(st_a), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      step();
      step();
      check("wait_l_state", 32'(st_a), 32'd1);
      check("wait_l_dac", 32'(dac_a), 32'd0);

      // Normal frame with 8001 (primes the repeat-last register)
      offer(16'h8001);
      check("ready_full", 32'(rdy_a), 32'd0);
      run_slot(1'b0, 16'h8001, 16'h8001, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'h8001, 16'h8001, 16, 1'b0, 1'b1);

      // Underflow: zeros vs. repeat of 8001
      run_slot(1'b0, 16'h0000, 16'h8001, 16, 1'b1, 1'b1);
      run_slot(1'b1, 16'h0000, 16'h8001, 16, 1'b0, 1'b1);

      // Mono playback of A5C3, right slot repeats, padding edge after 16 bits
      offer(16'hA5C3);
      check("ready_full_a5c3", 32'(rdy_a), 32'd0);
      run_slot(1'b0, 16'hA5C3, 16'hA5C3, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'hA5C3, 16'hA5C3, 17, 1'b0, 1'b1);
      check("wait_l_after_frame", 32'(st_a), 32'd1);

      // Backpressure: 5678 waits until 1234 is consumed
      valid = 1'b1;
      data = 16'h1234;
      data_r = 16'h1234;
      step();
      data = 16'h5678;
      data_r = 16'h5678;
      for (int t = 0; t < 3; t++) begin
         step();
         check("bp_ready_low", 32'(rdy_a), 32'd0);
      end
      run_slot(1'b0, 16'h1234, 16'h1234, 16, 1'b0, 1'b1);
      valid = 1'b0;
      run_slot(1'b1, 16'h1234, 16'h1234, 16, 1'b0, 1'b0);
      run_slot(1'b0, 16'h5678, 16'h5678, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'h5678, 16'h5678, 16, 1'b0, 1'b1);

      // Short slots: 8 bits of FFFF each side, next left slot starts right away
      offer(16'hFFFF);
      run_slot(1'b0, 16'hFFFF, 16'hFFFF, 8, 1'b0, 1'b1);
      valid = 1'b1;
      data = 16'h0F0F;
      data_r = 16'h0F0F;
      run_slot(1'b1, 16'hFFFF, 16'hFFFF, 8, 1'b0, 1'b0);
      valid = 1'b0;
      run_slot(1'b0, 16'h0F0F, 16'h0F0F, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'h0F0F, 16'h0F0F, 16, 1'b0, 1'b1);

      // Enable drops mid-frame: frame completes, buffer keeps its sample
      offer(16'h3C3C);
      run_slot(1'b0, 16'h3C3C, 16'h3C3C, 16, 1'b0, 1'b1);
      en = 1'b0;
      run_slot(1'b1, 16'h3C3C, 16'h3C3C, 17, 1'b0, 1'b1);
      offer(16'h5555);
      lrc = 1'b0;
      for (int t = 0; t < 4; t++) begin
         step();
         check("idle_dac", 32'(dac_a), 32'd0);
         check("idle_uf", 32'(uf_a), 32'd0);
      end
      check("idle_state", 32'(st_a), 32'd0);
      check("idle_ready_held", 32'(rdy_a), 32'd0);
      lrc = 1'b1;
      en  = 1'b1;
      step();
      step();
      check("rise_ignored_busy", 32'(busy_a), 32'd0);
      check("rise_ignored_dac", 32'(dac_a), 32'd0);
      run_slot(1'b0, 16'h5555, 16'h5555, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'h5555, 16'h5555, 16, 1'b0, 1'b1);

      // Reset at bit 5 of a left slot with a second sample pending
      offer(16'hFFFF);
      valid = 1'b1;
      data = 16'h1111;
      data_r = 16'h1111;
      run_slot(1'b0, 16'hFFFF, 16'hFFFF, 5, 1'b0, 1'b1);
      valid = 1'b0;
      check("pre_rst_ready", 32'(rdy_a), 32'd0);
      check("pre_rst_dac", 32'(dac_a), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_dac", 32'(dac_a), 32'd0);
      check("async_rst_ready", 32'(rdy_a), 32'd1);
      check("async_rst_busy", 32'(busy_a), 32'd0);
      #1;
      rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
         step();
         check("post_rst_dac", 32'(dac_a), 32'd0);
         check("post_rst_busy", 32'(busy_a), 32'd0);
      end
      lrc = 1'b1;
      step();
      check("post_rst_rise_busy", 32'(busy_a), 32'd0);
      run_slot(1'b0, 16'h0000, 16'h0000, 16, 1'b1, 1'b1);
      run_slot(1'b1, 16'h0000, 16'h0000, 16, 1'b0, 1'b1);

`ifdef AUD_PLAYER_STEREO_EN
      valid = 1'b1;
      data = 16'h00FF;
      data_r = 16'hFF00;
      step();
      valid = 1'b0;
      run_slot(1'b0, 16'h00FF, 16'h00FF, 16, 1'b0, 1'b1);
      run_slot(1'b1, 16'hFF00, 16'hFF00, 16, 1'b0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
